hdmi_line_fetcher: RTL and testbench

//  Avalon-MM burst read master feeding the HDMI transmit FIFO one video line per request.

---
 rtl/hdmi_pkg.sv | 11 +
 rtl/hdmi_line_fetcher.sv | 180 ++++++++++++++++++
 tb/tb_hdmi_line_fetcher.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared video constants and fetch FSM encoding for the HDMI line fetcher.
//   HACTIVE / VACTIVE : active pixels per line / active lines per frame
//   fetch_state_t     : IDLE (waiting for a request), ISSUE (sending read
//                       bursts), DRAIN (all bursts sent, waiting for the
//                       last beat of the line)
package hdmi_pkg;
  localparam int HACTIVE = 1280;
  localparam int VACTIVE = 720;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} fetch_state_t;
endpackage

// File: rtl/hdmi_line_fetcher.sv
// Avalon-MM burst read master that fetches one video line per request from
// the frame buffer and streams it out as one Avalon-ST packet (SOP/EOP).
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   line_request_i             pulse: fetch the next line
//   frame_sync_i               pulse: next line fetched is line 0
//   frame_base_i/_valid_i      frame base, takes effect at the next line 0
//   avm_*                      Avalon-MM read master (address, read,
//                              burstcount, waitrequest, readdata(valid))
//   aso_src_*                  Avalon-ST source, no backpressure
//   busy_o                     line fetch in progress
//   overrun_o                  sticky: request arrived while busy
module hdmi_line_fetcher
  import hdmi_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_PIXELS = HACTIVE,
  parameter int FRAME_LINES = VACTIVE,
  parameter int BURST_LEN   = 64,
  parameter int LINE_STRIDE = 5120,
  parameter int MAX_PENDING = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         line_request_i,
  input  logic                         frame_sync_i,
  input  logic [ADDR_WIDTH-1:0]        frame_base_i,
  input  logic                         frame_base_valid_i,
  output logic [ADDR_WIDTH-1:0]        avm_address_o,
  output logic                         avm_read_o,
  output logic [$clog2(BURST_LEN):0]   avm_burstcount_o,
  input  logic                         avm_waitrequest_i,
  input  logic [DATA_WIDTH-1:0]        avm_readdata_i,
  input  logic                         avm_readdatavalid_i,
  output logic                         aso_src_valid_o,
  output logic [DATA_WIDTH-1:0]        aso_src_data_o,
  output logic                         aso_src_startofpacket_o,
  output logic                         aso_src_endofpacket_o,
  output logic                         busy_o,
  output logic                         overrun_o
);
  localparam int BCW = $clog2(BURST_LEN) + 1;
  localparam int PXW = $clog2(LINE_PIXELS + 1);
  localparam int LIW = $clog2(FRAME_LINES + 1);
  localparam int PDW = $clog2(MAX_PENDING + 1);
  localparam int BBW = $clog2(BURST_LEN + 1);

  fetch_state_t          state_q, state_d;
  logic [LIW-1:0]        line_idx_q, line_idx_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] shadow_q, shadow_d;
  logic                  sync_pend_q, sync_pend_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PXW-1:0]        words_left_q, words_left_d;  // words not yet requested
  logic [PDW-1:0]        pending_q, pending_d;
  logic [PXW-1:0]        rx_cnt_q, rx_cnt_d;          // beats received this line
  logic [BBW-1:0]        bbeat_q, bbeat_d;            // beat index inside current burst
  logic                  out_vld_q, sop_q, eop_q, overrun_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic [BCW-1:0] burst_cnt;
  logic           rd, acc, beat_ok, burst_last;

  // Full bursts until the tail; burstcount is 0 outside ISSUE since words_left is 0.
  always_comb begin
    if (int'(words_left_q) >= BURST_LEN) burst_cnt = BCW'(BURST_LEN);
    else                                 burst_cnt = BCW'(words_left_q);
  end

  // read depends only on state and pending, and pending cannot rise while a
  // command is stalled, so the command stays asserted through waitrequest.
  assign rd         = (state_q == ISSUE) && (pending_q != PDW'(MAX_PENDING));
  assign acc        = rd && !avm_waitrequest_i;
  // Beats are only taken while a line is active; stale beats are dropped.
  assign beat_ok    = avm_readdatavalid_i && (state_q != IDLE) &&
                      (rx_cnt_q != PXW'(LINE_PIXELS));
  assign burst_last = beat_ok && ((bbeat_q == BBW'(BURST_LEN - 1)) ||
                                  (rx_cnt_q == PXW'(LINE_PIXELS - 1)));

  always_comb begin
    state_d      = state_q;
    line_idx_d   = line_idx_q;
    base_d       = base_q;
    shadow_d     = shadow_q;
    sync_pend_d  = sync_pend_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    rx_cnt_d     = rx_cnt_q;
    bbeat_d      = bbeat_q;
    pending_d    = pending_q + PDW'(acc) - PDW'(burst_last);

    if (frame_base_valid_i) shadow_d = frame_base_i;
    if (frame_sync_i)       sync_pend_d = 1'b1;

    if (beat_ok) begin
      rx_cnt_d = rx_cnt_q + PXW'(1);
      bbeat_d  = burst_last ? '0 : bbeat_q + BBW'(1);
    end

    unique case (state_q)
      IDLE: if (line_request_i) begin
        state_d      = ISSUE;
        words_left_d = PXW'(LINE_PIXELS);
        rx_cnt_d     = '0;
        bbeat_d      = '0;
        sync_pend_d  = 1'b0;
        // A pending (or simultaneous) frame sync restarts the frame here.
        if (sync_pend_q || frame_sync_i) begin
          line_idx_d = '0;
          base_d     = shadow_q;
          addr_d     = shadow_q;
        end else begin
          addr_d = base_q + ADDR_WIDTH'(line_idx_q) * ADDR_WIDTH'(LINE_STRIDE);
        end
      end
      ISSUE: if (acc) begin
        addr_d       = addr_q + ADDR_WIDTH'(burst_cnt) * ADDR_WIDTH'(DATA_WIDTH / 8);
        words_left_d = words_left_q - PXW'(burst_cnt);
        if (words_left_q == PXW'(burst_cnt)) state_d = DRAIN;
      end
      DRAIN: if (eop_q) begin
        state_d = IDLE;
        if (line_idx_q == LIW'(FRAME_LINES - 1)) begin
          line_idx_d = '0;
          base_d     = shadow_q;
        end else begin
          line_idx_d = line_idx_q + LIW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      line_idx_q   <= '0;
      base_q       <= '0;
      shadow_q     <= '0;
      sync_pend_q  <= 1'b0;
      addr_q       <= '0;
      words_left_q <= '0;
      pending_q    <= '0;
      rx_cnt_q     <= '0;
      bbeat_q      <= '0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_idx_q   <= line_idx_d;
      base_q       <= base_d;
      shadow_q     <= shadow_d;
      sync_pend_q  <= sync_pend_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      pending_q    <= pending_d;
      rx_cnt_q     <= rx_cnt_d;
      bbeat_q      <= bbeat_d;
      out_vld_q    <= beat_ok;
      out_data_q   <= avm_readdata_i;
      sop_q        <= beat_ok && (rx_cnt_q == '0);
      eop_q        <= beat_ok && (rx_cnt_q == PXW'(LINE_PIXELS - 1));
      if (line_request_i && (state_q != IDLE)) overrun_q <= 1'b1;
    end
  end

  assign avm_address_o           = addr_q;
  assign avm_read_o              = rd;
  assign avm_burstcount_o        = burst_cnt;
  assign aso_src_valid_o         = out_vld_q;
  assign aso_src_data_o          = out_data_q;
  assign aso_src_startofpacket_o = sop_q;
  assign aso_src_endofpacket_o   = eop_q;
  assign busy_o                  = (state_q != IDLE);
  assign overrun_o               = overrun_q;
endmodule

// File: tb/tb_hdmi_line_fetcher.sv
// Scoreboard bench for hdmi_line_fetcher: stimulus pushes expected commands
// and beats; a negedge monitor models the memory and compares outputs.
module tb_hdmi_line_fetcher;
  localparam int LP = 100;
  localparam int MP = 3;   // below the 4 bursts of a line so the limit is reached

  typedef struct packed { logic [31:0] d; logic sop; logic eop; } beat_t;
  typedef struct packed { logic [31:0] a; logic [5:0] bc; } cmd_t;
  typedef struct { logic [31:0] a; int bc; int rdy; } mreq_t;

  logic        clk = 0, reset = 1;
  logic        line_request_i = 0, frame_sync_i = 0, frame_base_valid_i = 0;
  logic [31:0] frame_base_i = 0;
  logic [31:0] avm_address_o;
  logic        avm_read_o;
  logic [5:0]  avm_burstcount_o;
  logic        avm_waitrequest_i = 0;
  logic [31:0] avm_readdata_i = 0;
  logic        avm_readdatavalid_i = 0;
  logic        aso_src_valid_o, aso_src_startofpacket_o, aso_src_endofpacket_o;
  logic [31:0] aso_src_data_o;
  logic        busy_o, overrun_o;

  hdmi_line_fetcher #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .LINE_PIXELS(LP), .FRAME_LINES(3),
    .BURST_LEN(32), .LINE_STRIDE(512), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(reset),
    .line_request_i(line_request_i), .frame_sync_i(frame_sync_i),
    .frame_base_i(frame_base_i), .frame_base_valid_i(frame_base_valid_i),
    .avm_address_o(avm_address_o), .avm_read_o(avm_read_o),
    .avm_burstcount_o(avm_burstcount_o), .avm_waitrequest_i(avm_waitrequest_i),
    .avm_readdata_i(avm_readdata_i), .avm_readdatavalid_i(avm_readdatavalid_i),
    .aso_src_valid_o(aso_src_valid_o), .aso_src_data_o(aso_src_data_o),
    .aso_src_startofpacket_o(aso_src_startofpacket_o),
    .aso_src_endofpacket_o(aso_src_endofpacket_o),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  beat_t exp_beat[$];
  cmd_t  exp_cmd[$];
  mreq_t mq[$];
  int cyc = 0, beats_seen = 0, wait_cyc = 0, lat = 0, wcnt = 0, beat_i = 0, stray = 0;
  int acc_line = 0, comp_line = 0, acc_at_first_beat = -1, comp_at_last_acc = -1;
  bit held = 0;
  logic [31:0] held_a;
  logic [5:0]  held_bc;
  beat_t eb;
  cmd_t  ec;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor + memory/interconnect model. Everything is decided at negedge
  // and takes effect at the following posedge.
  always @(negedge clk) begin
    cyc++;
    if (aso_src_valid_o) begin
      beats_seen++;
      if (exp_beat.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL stray_beat: got data 0x%0h, expected no beat", aso_src_data_o);
      end else begin
        eb = exp_beat.pop_front();
        chk("beat", {aso_src_data_o, aso_src_startofpacket_o, aso_src_endofpacket_o}, eb);
      end
    end
    if (reset) begin
      mq.delete(); beat_i = 0; wcnt = 0; held = 0;
      avm_waitrequest_i = 0; avm_readdatavalid_i = 0;
    end else begin
      if (held) chk("cmd_hold", {avm_read_o, avm_address_o, avm_burstcount_o}, {1'b1, held_a, held_bc});
      held = 0;
      avm_waitrequest_i = 0;
      if (avm_read_o) begin
        chk("pending_limit", 64'(acc_line - comp_line < MP), 1);
        if (wcnt < wait_cyc) begin
          avm_waitrequest_i = 1; wcnt++;
          held = 1; held_a = avm_address_o; held_bc = avm_burstcount_o;
        end else begin
          wcnt = 0;
          if (exp_cmd.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL extra_cmd: got addr 0x%0h bc %0d, expected none", avm_address_o, avm_burstcount_o);
          end else begin
            ec = exp_cmd.pop_front();
            chk("cmd", {avm_address_o, avm_burstcount_o}, ec);
          end
          mq.push_back('{a: avm_address_o, bc: int'(avm_burstcount_o), rdy: cyc + 1 + lat});
          acc_line++;
          if (acc_line == 4) comp_at_last_acc = comp_line;
        end
      end
      if (mq.size() != 0 && mq[0].rdy <= cyc) begin
        if (comp_line == 0 && beat_i == 0) acc_at_first_beat = acc_line;
        avm_readdatavalid_i = 1;
        avm_readdata_i = mq[0].a + 32'(4 * beat_i);
        beat_i++;
        if (beat_i >= mq[0].bc) begin
          void'(mq.pop_front()); beat_i = 0; comp_line++;
        end
      end else if (stray > 0) begin
        avm_readdatavalid_i = 1;
        avm_readdata_i = 32'hDEAD_0000 + 32'(stray);
        stray--;
      end else begin
        avm_readdatavalid_i = 0;
      end
    end
  end

  // Call at a negedge. Expected: bursts 32,32,32,4 at b+0x0/0x80/0x100/0x180,
  // pixels b+4*i, SOP on the first, EOP on the 100th.
  task automatic start_line(input logic [31:0] b, input logic sync);
    for (int i = 0; i < 4; i++)
      exp_cmd.push_back('{a: b + 32'(i * 128), bc: (i == 3) ? 6'd4 : 6'd32});
    for (int i = 0; i < LP; i++)
      exp_beat.push_back('{d: b + 32'(4 * i), sop: (i == 0), eop: (i == LP - 1)});
    beats_seen = 0; acc_line = 0; comp_line = 0;
    acc_at_first_beat = -1; comp_at_last_acc = -1;
    line_request_i = 1; frame_sync_i = sync;
    @(negedge clk);
    line_request_i = 0; frame_sync_i = 0;
    chk("req_latency", avm_read_o, 1);
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while ((exp_beat.size() != 0 || busy_o) && k < 3000) begin
      @(negedge clk); k++;
    end
    chk({nm, "_timeout"}, 64'(k < 3000), 1);
    chk({nm, "_beats"}, beats_seen, LP);
    chk({nm, "_cmds"}, acc_line, 4);
    chk({nm, "_left"}, exp_beat.size() + exp_cmd.size(), 0);
    exp_beat.delete(); exp_cmd.delete();
    @(negedge clk);
  endtask

  task automatic pulse_base(input logic [31:0] b);
    frame_base_i = b; frame_base_valid_i = 1;
    @(negedge clk);
    frame_base_valid_i = 0;
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_avm", {avm_address_o, avm_read_o, avm_burstcount_o}, 0);
    chk("rst_aso", {aso_src_valid_o, aso_src_data_o, aso_src_startofpacket_o,
                    aso_src_endofpacket_o, busy_o, overrun_o}, 0);
    reset = 0;
    @(negedge clk);

    // T1: sync + request together fetch line 0 of base 0x1000
    pulse_base(32'h1000);
    start_line(32'h1000, 1); wait_done("t1");

    // T2: 5-cycle waitrequest per command; lone sync pulse applies to next line
    wait_cyc = 5;
    frame_sync_i = 1; @(negedge clk); frame_sync_i = 0;
    repeat (2) @(negedge clk);
    start_line(32'h1000, 0); wait_done("t2");

    // T3: 40-cycle memory latency, command stream stalls at MP outstanding
    wait_cyc = 0; lat = 40;
    start_line(32'h1200, 0); wait_done("t3");
    chk("t3_acc_before_data", acc_at_first_beat, MP);
    chk("t3_last_acc_after_ret", comp_at_last_acc, 1);

    // T4: line sequence with wrap, then a new base given mid-frame
    lat = 0;
    start_line(32'h1000, 1); wait_done("t4_l0");
    start_line(32'h1200, 0); wait_done("t4_l1");
    start_line(32'h1400, 0); wait_done("t4_l2");
    start_line(32'h1000, 0); wait_done("t4_wrap");
    start_line(32'h1200, 0);
    repeat (20) @(negedge clk);
    pulse_base(32'h8000);
    wait_done("t4_l1b");
    start_line(32'h1400, 0); wait_done("t4_l2b");
    start_line(32'h8000, 0); wait_done("t4_newbase");

    // T5: request while busy is dropped and flagged
    chk("t5_ovr_before", overrun_o, 0);
    start_line(32'h8200, 0);
    repeat (10) @(negedge clk);
    line_request_i = 1; @(negedge clk); line_request_i = 0;
    wait_done("t5");
    chk("t5_ovr_after", overrun_o, 1);

    // T6: reset at beat 50, stale beats ignored, fresh line 0 at base 0
    start_line(32'h8400, 0);
    k = 0;
    while (beats_seen < 50 && k < 2000) begin @(negedge clk); k++; end
    chk("t6_reach_50", 64'(k < 2000), 1);
    reset = 1;
    @(posedge clk); #1;
    chk("t6_rst_avm", {avm_address_o, avm_read_o, avm_burstcount_o}, 0);
    chk("t6_rst_aso", {aso_src_valid_o, aso_src_data_o, aso_src_startofpacket_o,
                       aso_src_endofpacket_o, busy_o, overrun_o}, 0);
    exp_beat.delete(); exp_cmd.delete();
    @(negedge clk); @(negedge clk);
    reset = 0;
    beats_seen = 0; stray = 3;
    repeat (10) @(negedge clk);
    chk("t6_stray_dropped", beats_seen, 0);
    start_line(32'h0, 0); wait_done("t6_fresh");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
